quad_tachometer: RTL and testbench

Parametrised quadrature tachometer: synchronises and glitch-filters encoder channels A/B, decodes them at 4x resolution with direction, keeps a signed running position, and once per configurable gate window reports a signed RPM from a fixed-latency sequential divider. It sits between the motor encoder pins and the AXI register block. It supersedes the single-channel, direction-blind, fixed-2 s tachometer.

---
 rtl/quad_tachometer.sv | 194 +++++++++++++++++++
 tb/tb_quad_tachometer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_tachometer.sv
// Quadrature tachometer: synchronised/filtered A/B decode at 4x with direction,
// signed running position, and a per-window signed RPM from a sequential divider.
module quad_tachometer #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned GATE_MS    = 1000,
    parameter int unsigned PPR        = 12,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned RPM_W      = 32,
    parameter int unsigned POS_W      = 32
) (
    input  logic                    refclk,
    input  logic                    resetN,
    input  logic                    pinA,
    input  logic                    pinB,
    input  logic                    clear_pos,
    input  logic                    err_clr,
    output logic signed [RPM_W-1:0] rpm,
    output logic                    rpm_valid,
    output logic signed [POS_W-1:0] position,
    output logic                    dir,
    output logic                    quad_err,
    output logic                    gate_tick
);

    localparam int unsigned WIN_N     = CLK_FREQ / 1000 * GATE_MS;
    localparam int unsigned WIN_W     = $clog2(WIN_N);
    localparam int unsigned FLT_W     = $clog2(FILTER_LEN + 1);
    localparam int unsigned DIV_W     = RPM_W + 17;
    localparam int unsigned SH_W      = DIV_W + 1;
    localparam int unsigned STEP_W    = $clog2(DIV_W + 1);
    localparam int unsigned DIVISOR   = 4 * PPR * GATE_MS;
    localparam int unsigned RPM_SCALE = 60000;

    localparam logic signed [RPM_W-1:0] ACC_MAX = {1'b0, {(RPM_W-1){1'b1}}};
    localparam logic signed [RPM_W-1:0] ACC_MIN = {1'b1, {(RPM_W-1){1'b0}}};
    localparam logic [DIV_W-1:0]        MAG_MAX = DIV_W'({(RPM_W-1){1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    // Index 1 = channel A, index 0 = channel B
    logic [1:0]       r_meta, r_sync, r_filt, r_prev;
    logic [FLT_W-1:0] r_flt_cnt [2];
    logic [WIN_W-1:0] r_win_cnt;
    logic signed [RPM_W-1:0] r_acc;
    state_t           r_state;
    logic [DIV_W-1:0] r_quo, r_rem;
    logic [STEP_W-1:0] r_step;
    logic             r_neg;

    logic [1:0]       w_delta;
    logic             w_fwd, w_rev, w_ill;
    logic signed [RPM_W-1:0] w_acc_sum;
    logic [RPM_W-1:0] w_mag;
    logic [DIV_W-1:0] w_prod, w_rem_next;
    logic [SH_W-1:0]  w_shift;
    logic             w_ge;
    logic signed [RPM_W-1:0] w_rpm_res;

    // Gray position of an {A,B} pair along the forward sequence 00->10->11->01
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_idx = 2'd0;
            2'b10:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    always_comb begin
        w_delta = gray_idx(r_filt) - gray_idx(r_prev);
        w_fwd   = (w_delta == 2'd1);
        w_rev   = (w_delta == 2'd3);
        w_ill   = (w_delta == 2'd2);

        w_acc_sum = r_acc;
        if (w_fwd && (r_acc != ACC_MAX)) begin
            w_acc_sum = r_acc + RPM_W'(1);
        end else if (w_rev && (r_acc != ACC_MIN)) begin
            w_acc_sum = r_acc - RPM_W'(1);
        end

        w_mag  = w_acc_sum[RPM_W-1] ? (~w_acc_sum + RPM_W'(1)) : w_acc_sum;
        w_prod = DIV_W'(w_mag) * DIV_W'(RPM_SCALE);

        w_shift    = {r_rem, r_quo[DIV_W-1]};
        w_ge       = (w_shift >= SH_W'(DIVISOR));
        w_rem_next = w_ge ? DIV_W'(w_shift - SH_W'(DIVISOR)) : DIV_W'(w_shift);

        if (r_quo > MAG_MAX) begin
            w_rpm_res = r_neg ? ACC_MIN : ACC_MAX;
        end else begin
            w_rpm_res = r_neg ? -RPM_W'(r_quo) : RPM_W'(r_quo);
        end
    end

    // Pin synchroniser and per-channel stability filter
    always_ff @(posedge refclk) begin
        if (!resetN) begin
            r_meta <= '0;
            r_sync <= '0;
            r_filt <= '0;
            r_prev <= '0;
            for (int i = 0; i < 2; i++) r_flt_cnt[i] <= '0;
        end else begin
            r_meta <= {pinA, pinB};
            r_sync <= r_meta;
            r_prev <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_filt[i]) begin
                    r_flt_cnt[i] <= '0;
                end else if (r_flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
                    r_filt[i]    <= r_sync[i];
                    r_flt_cnt[i] <= '0;
                end else begin
                    r_flt_cnt[i] <= r_flt_cnt[i] + FLT_W'(1);
                end
            end
        end
    end

    // Position, direction, sticky error, gate window and window accumulator
    always_ff @(posedge refclk) begin
        if (!resetN) begin
            position  <= '0;
            dir       <= 1'b0;
            quad_err  <= 1'b0;
            r_win_cnt <= '0;
            gate_tick <= 1'b0;
            r_acc     <= '0;
        end else begin
            if (clear_pos) begin
                position <= '0;
            end else if (w_fwd) begin
                position <= position + POS_W'(1);
            end else if (w_rev) begin
                position <= position - POS_W'(1);
            end
            if (w_fwd) begin
                dir <= 1'b1;
            end else if (w_rev) begin
                dir <= 1'b0;
            end
            if (w_ill) begin
                quad_err <= 1'b1;
            end else if (err_clr) begin
                quad_err <= 1'b0;
            end
            r_win_cnt <= (r_win_cnt == WIN_W'(WIN_N - 1)) ? '0 : r_win_cnt + WIN_W'(1);
            gate_tick <= (r_win_cnt == WIN_W'(WIN_N - 2));
            r_acc     <= gate_tick ? '0 : w_acc_sum;
        end
    end

    // Rate FSM: capture |count|*60000, restoring divide one bit per cycle, publish
    always_ff @(posedge refclk) begin
        if (!resetN) begin
            r_state   <= S_IDLE;
            r_quo     <= '0;
            r_rem     <= '0;
            r_step    <= '0;
            r_neg     <= 1'b0;
            rpm       <= '0;
            rpm_valid <= 1'b0;
        end else begin
            rpm_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (gate_tick) begin
                        r_quo   <= w_prod;
                        r_rem   <= '0;
                        r_step  <= '0;
                        r_neg   <= w_acc_sum[RPM_W-1];
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_quo  <= {r_quo[DIV_W-2:0], w_ge};
                    r_rem  <= w_rem_next;
                    r_step <= r_step + STEP_W'(1);
                    if (r_step == STEP_W'(DIV_W - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    rpm       <= w_rpm_res;
                    rpm_valid <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_tachometer.sv
// Directed bench for quad_tachometer: 1 MHz clock, 1 ms window, 12 PPR, filter 4.
module tb_quad_tachometer;

    logic               refclk;
    logic               resetN;
    logic               pinA, pinB;
    logic               clear_pos, err_clr;
    logic signed [31:0] rpm;
    logic               rpm_valid;
    logic signed [31:0] position;
    logic               dir, quad_err, gate_tick;

    int  n_vec;
    int  n_err;
    int  k;
    bit  saw_valid;
    logic [1:0] idx;

    quad_tachometer #(
        .CLK_FREQ  (1_000_000),
        .GATE_MS   (1),
        .PPR       (12),
        .FILTER_LEN(4),
        .RPM_W     (32),
        .POS_W     (32)
    ) dut (
        .refclk   (refclk),
        .resetN   (resetN),
        .pinA     (pinA),
        .pinB     (pinB),
        .clear_pos(clear_pos),
        .err_clr  (err_clr),
        .rpm      (rpm),
        .rpm_valid(rpm_valid),
        .position (position),
        .dir      (dir),
        .quad_err (quad_err),
        .gate_tick(gate_tick)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge refclk);
        if (rpm_valid) saw_valid = 1'b1;
    endtask

    task automatic set_ab(input logic [1:0] i);
        case (i)
            2'd0: {pinA, pinB} = 2'b00;
            2'd1: {pinA, pinB} = 2'b10;
            2'd2: {pinA, pinB} = 2'b11;
            default: {pinA, pinB} = 2'b01;
        endcase
    endtask

    task automatic quad_edge(input bit fwd);
        idx = fwd ? idx + 2'd1 : idx - 2'd1;
        set_ab(idx);
        repeat (8) step();
    endtask

    task automatic wait_gate(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!gate_tick && cyc < 3000);
        chk("gate_seen", gate_tick, 1);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!rpm_valid && cyc < 200);
        chk("rpm_valid_seen", rpm_valid, 1);
    endtask

    initial begin
        n_vec = 0; n_err = 0; saw_valid = 1'b0; idx = 2'd0;
        resetN = 1'b0; pinA = 1'b0; pinB = 1'b0; clear_pos = 1'b0; err_clr = 1'b0;
        repeat (3) step();
        chk("rst_rpm", rpm, 0);
        chk("rst_rpm_valid", rpm_valid, 0);
        chk("rst_position", position, 0);
        chk("rst_dir", dir, 0);
        chk("rst_quad_err", quad_err, 0);
        chk("rst_gate_tick", gate_tick, 0);
        resetN = 1'b1;
        wait_gate(k);
        chk("first_gate_cycle", k, 999);

        // 48 forward edges in one window: one revolution in 1 ms
        for (int i = 0; i < 48; i++) quad_edge(1'b1);
        chk("fwd_position", position, 48);
        chk("fwd_dir", dir, 1);
        wait_gate(k);
        wait_valid(k);
        chk("rpm_latency", k, 51);
        chk("rpm_fwd", rpm, 60000);
        step();
        chk("rpm_valid_pulse", rpm_valid, 0);
        chk("rpm_hold", rpm, 60000);

        // Clear then 24 reverse edges
        clear_pos = 1'b1;
        step();
        clear_pos = 1'b0;
        step();
        chk("clear_position", position, 0);
        for (int i = 0; i < 24; i++) quad_edge(1'b0);
        chk("rev_position", position, -24);
        chk("rev_dir", dir, 0);
        wait_gate(k);
        wait_valid(k);
        chk("rpm_rev", rpm, -30000);

        // 2-cycle glitch on A is filtered; window sees no edges
        pinA = 1'b1;
        repeat (2) step();
        pinA = 1'b0;
        repeat (10) step();
        chk("glitch_position", position, -24);
        chk("glitch_quad_err", quad_err, 0);
        wait_gate(k);
        wait_valid(k);
        chk("rpm_zero", rpm, 0);

        // Illegal 00->11 jump
        {pinA, pinB} = 2'b11;
        repeat (10) step();
        chk("ill_quad_err", quad_err, 1);
        chk("ill_position", position, -24);
        chk("ill_dir", dir, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        chk("err_clr", quad_err, 0);
        // Illegal 11->00 with err_clr on the very cycle the error sets
        {pinA, pinB} = 2'b00;
        repeat (6) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("ill_clr_same_cycle", quad_err, 1);
        step();
        chk("ill_clr_sticky", quad_err, 1);
        chk("ill2_position", position, -24);

        // Stable change on A: exactly one forward count
        idx = 2'd0;
        quad_edge(1'b1);
        chk("stable_position", position, -23);
        chk("stable_dir", dir, 1);

        // clear_pos on the same cycle a forward edge reaches position
        idx = idx + 2'd1;
        set_ab(idx);
        repeat (6) step();
        clear_pos = 1'b1;
        step();
        clear_pos = 1'b0;
        chk("clear_wins_edge", position, 0);
        step();
        chk("clear_after", position, 0);
        wait_gate(k);
        wait_valid(k);
        chk("rpm_two_edges", rpm, 2500);

        // Reset in the middle of a divide
        wait_gate(k);
        repeat (10) step();
        saw_valid = 1'b0;
        resetN = 1'b0;
        pinA = 1'b0; pinB = 1'b0;
        step();
        chk("midrst_rpm", rpm, 0);
        chk("midrst_rpm_valid", rpm_valid, 0);
        chk("midrst_position", position, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_quad_err", quad_err, 0);
        chk("midrst_gate_tick", gate_tick, 0);
        repeat (2) step();
        resetN = 1'b1;
        wait_gate(k);
        chk("postrst_gate_cycle", k, 999);
        chk("postrst_no_valid", saw_valid, 0);
        chk("postrst_quad_err", quad_err, 0);
        chk("postrst_position", position, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
